// File: rtl/div_controller.sv
// div_controller: signed restoring divider, one shift-subtract step per cycle, quotient toward zero.
// Optional DIV_ZERO_DETECT_EN adds a div_by_zero flag and an early exit for a zero divisor.
module div_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef DIV_ZERO_DETECT_EN
  output logic             div_by_zero,
`endif
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sn_q, sn_d, sq_q, sq_d, zf_q, zf_d, done_q, done_d, dz, ge;
  logic [WIDTH:0] dvs_q, dvs_d, shf;
  logic [WIDTH-1:0] acc_q, acc_d, par_q, par_d, quo_q, quo_d, rem_q, rem_d, mag;
`ifdef DIV_ZERO_DETECT_EN
  logic dbz_q, dbz_d;
  assign div_by_zero = dbz_q;
`endif
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;
  // Dividend magnitude fits WIDTH bits even for the most-negative value; the divisor needs one more
  assign mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign shf = {par_q, acc_q[WIDTH-1]};
  assign ge  = shf >= dvs_q;
  assign dz  = ZD && divisor == '0;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? (dz ? DONE : RUN) : IDLE;
      RUN:     state_d = cnt_q == CW'(WIDTH - 1) ? FIX : RUN;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cnt_d  = cnt_q;
    sn_d   = sn_q;
    sq_d   = sq_q;
    zf_d   = zf_q;
    dvs_d  = dvs_q;
    acc_d  = acc_q;
    par_d  = par_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    done_d = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
    dbz_d  = dbz_q;
`endif
    if (state_q == IDLE && start) begin
      cnt_d = '0;
      sn_d  = dividend[WIDTH-1];
      sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      zf_d  = dz;
      dvs_d = divisor[WIDTH-1] ? -{1'b1, divisor} : {1'b0, divisor};
      acc_d = mag;
      par_d = dz ? mag : '0;
    end
    if (state_q == RUN) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = {acc_q[WIDTH-2:0], ge};
      par_d = ge ? WIDTH'(shf - dvs_q) : shf[WIDTH-1:0];
    end
    // Zero-divisor early exit finishes from DONE, keeping the remainder path shared
    if (state_q == FIX || (state_q == DONE && zf_q)) begin
      quo_d  = zf_q ? '1 : (sq_q ? -acc_q : acc_q);
      rem_d  = sn_q ? -par_q : par_q;
      done_d = 1'b1;
`ifdef DIV_ZERO_DETECT_EN
      dbz_d  = zf_q;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sn_q   <= 1'b0;
      sq_q   <= 1'b0;
      zf_q   <= 1'b0;
      dvs_q  <= '0;
      acc_q  <= '0;
      par_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      sn_q   <= sn_d;
      sq_q   <= sq_d;
      zf_q   <= zf_d;
      dvs_q  <= dvs_d;
      acc_q  <= acc_d;
      par_q  <= par_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      done_q <= done_d;
`ifdef DIV_ZERO_DETECT_EN
      dbz_q  <= dbz_d;
`endif
    end
  end
endmodule

// File: tb/tb_div_controller.sv
// tb_div_controller: scoreboard bench for div_controller at WIDTH=8, directed steps plus a random sweep.
module tb_div_controller;
  localparam int W = 8;
  logic clk, rst, start, done, dbz;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  typedef struct {logic [W-1:0] q; logic [W-1:0] r; int cyc; logic z;} ent_t;
  ent_t sb[$];
  ent_t e;
  int cyc = 0, nvec = 0, nerr = 0, ndone = 0, c0, nd0;
  div_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
`ifdef DIV_ZERO_DETECT_EN
    .div_by_zero(dbz),
`endif
    .done(done)
  );
`ifndef DIV_ZERO_DETECT_EN
  assign dbz = 1'b0;
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  function automatic ent_t model(input int a, input int b, input int c);
    ent_t m;
    int qq;
    m.z = 1'b0;
    m.cyc = c + W + 1;
    if (b == 0) begin
`ifdef DIV_ZERO_DETECT_EN
      qq = -1;
      m.z = 1'b1;
      m.cyc = c + 1;
`else
      qq = a >= 0 ? -1 : 1;
`endif
      m.r = W'(a);
    end else begin
      qq = a / b;
      m.r = W'(a - qq * b);
    end
    m.q = W'(qq);
    return m;
  endfunction
  task automatic go(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input bit push);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1 start = 1'b0;
    if (push) sb.push_back(model(int'(a), int'(b), cyc));
  endtask
  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain_pending", sb.size(), 0);
    @(posedge clk);
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      ndone++;
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("done_cycle", cyc, e.cyc);
`ifdef DIV_ZERO_DETECT_EN
        chk("div_by_zero", dbz, e.z);
`endif
      end
    end
  end
  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    rst = 1'b0;
    go(100, 7, 1);     wait_drain(30);
    go(-100, 7, 1);    wait_drain(30);
    go(100, -7, 1);    wait_drain(30);
    go(-100, -7, 1);   wait_drain(30);
    go(-128, -1, 1);   wait_drain(30);
    go(-128, 1, 1);    wait_drain(30);
    go(127, 127, 1);   wait_drain(30);
    go(5, 0, 1);       wait_drain(30);
    go(-5, 0, 1);      wait_drain(30);
    go(-128, 0, 1);    wait_drain(30);
    go(1, -128, 1);    wait_drain(30);
    // Reset lands on E0+4 of an in-flight division
    nd0 = ndone;
    go(100, 7, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_done", done, 0);
    repeat (15) @(negedge clk);
    chk("midrst_no_done", ndone, nd0);
    chk("midrst_hold_q", quotient, 0);
    go(50, 3, 1);      wait_drain(30);
    // Start held high; operands change mid-RUN, second op accepted right after DONE
    @(negedge clk);
    start = 1'b1;
    dividend = 100;
    divisor = 7;
    @(posedge clk);
    #1 c0 = cyc;
    sb.push_back(model(100, 7, c0));
    sb.push_back(model(50, 3, c0 + W + 3));
    repeat (2) @(negedge clk);
    dividend = 50;
    divisor = 3;
    for (int i = 0; i < 40 && cyc < c0 + W + 3; i++) @(negedge clk);
    start = 1'b0;
    dividend = 8'h55;
    divisor = 8'h11;
    wait_drain(60);
    @(negedge clk);
    chk("hold_quotient", quotient, 16);
    chk("hold_remainder", remainder, 2);
    for (int i = 0; i < 24; i++) begin
      go($urandom_range(255), $urandom_range(255), 1);
      wait_drain(30);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
